// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_unit                                                            |
// | Load/store sequencer: single-word writes and 1..4 beat read bursts between |
// | a valid/ready request port and a 256x16 combinational-read data memory.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_access_unit #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int LW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [LW-1:0] req_len,
  input  logic [DW-1:0] req_wdata,
  output logic          wr_done,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_WRITE = 2'd1;
  localparam logic [1:0] c_READ  = 2'd2;
  localparam logic [1:0] c_RESP  = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_beat;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rsp_data;
  logic          r_rsp_valid;
  logic          r_rsp_last;
  logic          r_wr_done;
  logic          w_accept;
  logic          w_rsp_hs;

  assign w_accept = (r_state == c_IDLE) && req_valid;
  assign w_rsp_hs = (r_state == c_RESP) && r_rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (req_valid) begin
          w_state_next = req_we ? c_WRITE : c_READ;
        end
      end
      c_WRITE: w_state_next = c_IDLE;
      c_READ:  w_state_next = c_RESP;
      c_RESP: begin
        if (w_rsp_hs) begin
          w_state_next = r_rsp_last ? c_IDLE : c_READ;
        end
      end
      default: w_state_next = c_IDLE;
    endcase
  end

  // Memory strobes are pure state decodes so they drop the instant reset asserts.
  always_comb begin
    req_ready = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    case (r_state)
      c_IDLE:  req_ready = 1'b1;
      c_WRITE: mem_wr    = 1'b1;
      c_READ:  mem_rd    = 1'b1;
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr      <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_wdata     <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_wr_done   <= 1'b0;
    end else begin
      r_wr_done <= (r_state == c_WRITE);
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_len   <= req_len;
        r_beat  <= '0;
      end
      if (r_state == c_READ) begin
        r_rsp_data  <= mem_rdata;
        r_rsp_valid <= 1'b1;
        r_rsp_last  <= (r_beat == r_len);
      end
      // Address wraps naturally at 2^AW.
      if (w_rsp_hs) begin
        r_rsp_valid <= 1'b0;
        r_rsp_last  <= 1'b0;
        if (!r_rsp_last) begin
          r_addr <= r_addr + 1'b1;
          r_beat <= r_beat + 1'b1;
        end
      end
    end
  end

  assign wr_done   = r_wr_done;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_last  = r_rsp_last;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_access_unit                                                         |
// | Directed scoreboard bench for mem_access_unit with a 256x16 memory model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [1:0]  req_len;
  logic [15:0] req_wdata;
  logic        wr_done;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_last;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  wire  [15:0] mem_rdata;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } beat_t;

  beat_t      sb[$];
  logic [7:0] addr_log[$];
  logic [15:0] tb_mem [256];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;

  int checks = 0;
  int failures = 0;
  int rd_cycles = 0;
  int wr_cycles = 0;
  int both_cycles = 0;
  int wr_done_cnt = 0;
  int rsp_seen = 0;
  int wr_during_burst = 0;

  mem_access_unit #(.AW(8), .DW(16), .LW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .wr_done   (wr_done),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: write on clock edge, combinational read, floating when not read.
  always @(posedge clk) begin
    if (pl_en) tb_mem[pl_addr] <= pl_data;
    else if (mem_wr) tb_mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem_rd ? tb_mem[mem_addr] : 16'hzzzz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Observe the current cycle, pop/compare any beat handshaking at the next edge, then advance.
  task automatic step();
    beat_t e;
    if (mem_rd) begin addr_log.push_back(mem_addr); rd_cycles++; end
    if (mem_wr) begin wr_cycles++; if (sb.size() != 0) wr_during_burst++; end
    if (mem_rd && mem_wr) both_cycles++;
    if (wr_done) wr_done_cnt++;
    if (rsp_valid) rsp_seen++;
    if (rsp_valid && rsp_ready) begin
      check("beat_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_last", 32'(rsp_last), 32'(e.last));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [15:0] d, input logic l);
    beat_t e;
    e.data = d; e.last = l;
    sb.push_back(e);
  endtask

  initial begin
    logic [7:0] exp_addr [4];
    int wd0, rs0;
    exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00; exp_addr[3] = 8'h01;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    req_wdata = '0; rsp_ready = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;

    // Reset state
    #3;
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_mem_rd", 32'(mem_rd), 0);
    check("rst_mem_wr", 32'(mem_wr), 0);
    check("rst_wr_done", 32'(wr_done), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Single write
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 16'hBEEF;
    check("wr_req_ready", 32'(req_ready), 1);
    step();
    req_valid = 1'b0;
    check("wr_mem_wr", 32'(mem_wr), 1);
    check("wr_mem_addr", 32'(mem_addr), 32'h10);
    check("wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    check("wr_busy_ready", 32'(req_ready), 0);
    check("wr_done_early", 32'(wr_done), 0);
    step();
    check("wr_done_pulse", 32'(wr_done), 1);
    check("wr_mem_wr_off", 32'(mem_wr), 0);
    check("wr_idle_ready", 32'(req_ready), 1);
    step();
    check("wr_done_one", 32'(wr_done), 0);
    check("wr_mem_word", 32'(tb_mem[8'h10]), 32'hBEEF);

    // Single read
    preload(8'h10, 16'hBEEF);
    push(16'hBEEF, 1'b1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; req_len = 2'd0;
    step();
    req_valid = 1'b0;
    check("rd_mem_rd", 32'(mem_rd), 1);
    check("rd_not_valid_yet", 32'(rsp_valid), 0);
    step();
    check("rd_valid", 32'(rsp_valid), 1);
    check("rd_data", 32'(rsp_data), 32'hBEEF);
    check("rd_mem_rd_off", 32'(mem_rd), 0);
    step();
    check("rd_ready_after", 32'(req_ready), 1);
    check("rd_valid_cleared", 32'(rsp_valid), 0);
    check("rd_sb_empty", 32'(sb.size()), 0);

    // Wrapping burst
    preload(8'hFE, 16'h1111); preload(8'hFF, 16'h2222);
    preload(8'h00, 16'h3333); preload(8'h01, 16'h4444);
    push(16'h1111, 1'b0); push(16'h2222, 1'b0); push(16'h3333, 1'b0); push(16'h4444, 1'b1);
    addr_log.delete(); rd_cycles = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hFE; req_len = 2'd3;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 30 && sb.size() != 0; i++) step();
    check("burst_sb_empty", 32'(sb.size()), 0);
    check("burst_rd_cycles", 32'(rd_cycles), 4);
    check("burst_log_len", 32'(addr_log.size()), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      check("burst_mem_addr", 32'(addr_log[i]), 32'(exp_addr[i]));
    check("burst_idle_ready", 32'(req_ready), 1);

    // Backpressure on beat 2
    push(16'h1111, 1'b0); push(16'h2222, 1'b0); push(16'h3333, 1'b0); push(16'h4444, 1'b1);
    rd_cycles = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hFE; req_len = 2'd3;
    step();
    req_valid = 1'b0;
    step();
    step();
    step();
    check("bp_beat2_valid", 32'(rsp_valid), 1);
    check("bp_beat2_data", 32'(rsp_data), 32'h2222);
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", 32'(rsp_valid), 1);
      check("bp_hold_data", 32'(rsp_data), 32'h2222);
      check("bp_no_mem_rd", 32'(mem_rd), 0);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 30 && sb.size() != 0; i++) step();
    check("bp_sb_empty", 32'(sb.size()), 0);
    check("bp_rd_cycles", 32'(rd_cycles), 4);

    // Write request held while busy
    push(16'h1111, 1'b0); push(16'h2222, 1'b1);
    wr_cycles = 0; wd0 = wr_done_cnt; wr_during_burst = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hFE; req_len = 2'd1;
    step();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20; req_wdata = 16'hCAFE;
    rsp_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("busy_req_ready", 32'(req_ready), 0);
      check("busy_no_mem_wr", 32'(wr_cycles), 0);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 30 && wr_done_cnt == wd0; i++) begin
      if (req_ready) begin
        step();
        req_valid = 1'b0;
      end else begin
        step();
      end
    end
    check("busy_wr_done", 32'(wr_done_cnt - wd0), 1);
    check("busy_wr_cycles", 32'(wr_cycles), 1);
    check("busy_wr_after_burst", 32'(wr_during_burst), 0);
    check("busy_sb_empty", 32'(sb.size()), 0);
    check("busy_mem_word", 32'(tb_mem[8'h20]), 32'hCAFE);
    req_valid = 1'b0;
    step();

    // Asynchronous reset in the middle of a burst
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; req_len = 2'd3;
    step();
    req_valid = 1'b0;
    check("ar_in_read", 32'(mem_rd), 1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_mem_rd", 32'(mem_rd), 0);
    check("ar_rsp_valid", 32'(rsp_valid), 0);
    check("ar_rsp_last", 32'(rsp_last), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    wd0 = wr_done_cnt; rs0 = rsp_seen;
    check("ar_req_ready", 32'(req_ready), 1);
    for (int i = 0; i < 6; i++) step();
    check("ar_no_wr_done", 32'(wr_done_cnt - wd0), 0);
    check("ar_no_rsp", 32'(rsp_seen - rs0), 0);
    check("ar_idle_ready", 32'(req_ready), 1);
    check("never_rd_and_wr", 32'(both_cycles), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer between the CPU datapath and the 256x16 data memory.
- Accepts single-word write requests and 1–4 word sequential read bursts through a valid/ready request port.
- Drives the memory's addr/rd/wr/W_data pins and captures the memory's combinational read data (high-Z when rd is low) into a registered response with valid/ready backpressure.

Parameters:
AW, 8, address width; matches data memory depth of 256 words
DW, 16, data word width
LW, 2, burst length field width; burst beats = req_len + 1 (1..4)

Ports:
clk        input   1   single clock, rising edge
rst        input   1   reset; one clock; reset is asynchronous and active-low
req_valid  input   1   request present
req_ready  output  1   unit can accept a request
req_we     input   1   1 = write, 0 = read
req_addr   input   AW  start word address
req_len    input   LW  read beats minus one; ignored for writes
req_wdata  input   DW  write data
wr_done    output  1   one-cycle pulse: write committed to memory
rsp_valid  output  1   read data beat available
rsp_ready  input   1   consumer accepts beat
rsp_data   output  DW  read data beat
rsp_last   output  1   final beat of burst, qualified by rsp_valid
mem_addr   output  AW  to data memory addr
mem_rd     output  1   to data memory rd
mem_wr     output  1   to data memory wr
mem_wdata  output  DW  to data memory W_data
mem_rdata  input   DW  from data memory R_data; valid only while mem_rd=1

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; addr_q, len_q, beat_q, wdata_q, rsp_data all 0; req_ready=1 once in IDLE; wr_done, rsp_valid, rsp_last, mem_rd, mem_wr = 0 immediately, with no clock needed.
- mem_rd/mem_wr are Moore outputs decoded from state only, never combinational from req_*. mem_addr=addr_q, mem_wdata=wdata_q.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch addr, wdata, and len, then set beat_q=0.
  - Next state is WRITE if req_we=1, else READ.
- WRITE:
  - req_ready=0; mem_wr=1 for exactly one cycle (the memory captures at this cycle's edge).
  - Next state is IDLE.
  - wr_done=1 in the cycle after WRITE, i.e. in the first IDLE cycle.
  - Write latency: accept edge +2 cycles to wr_done.
- READ:
  - mem_rd=1 for exactly one cycle.
  - At the edge: rsp_data<=mem_rdata, rsp_valid<=1, rsp_last<=(beat_q==len_q).
  - Next state is RESP.
- RESP:
  - mem_rd=0; rsp_valid, rsp_data, and rsp_last are held stable until rsp_ready=1.
  - On rsp_valid&&rsp_ready: rsp_valid<=0 and rsp_last<=0.
    - If last, go to IDLE.
    - Otherwise addr_q<=addr_q+1 and beat_q<=beat_q+1, then go to READ.
- Read timing: first beat rsp_valid 2 cycles after the accept edge. Throughput is 1 beat per 2 cycles with rsp_ready tied high.
- Address wrap: addr_q increments modulo 2^AW (255 -> 0); no error is flagged.
- req_ready is 0 in every state except IDLE. A request held on req_valid while the unit is busy is not accepted and is not lost; it is accepted on return to IDLE.
- Back-to-back:
  - A new request may be accepted in the same IDLE cycle that wr_done is pulsing.
  - After the last read beat handshakes, IDLE is entered next cycle.
- Backpressure: while rsp_ready=0 the memory is not accessed (mem_rd=0), so the captured beat is never overwritten.
- mem_rd and mem_wr are never 1 in the same cycle.
- Reset mid-burst: the burst is abandoned and no further beats or wr_done are produced. After release, the unit is in IDLE.

Test Plan:
- Reset then write: req{we=1, addr=0x10, wdata=0xBEEF} -> mem_wr=1 with mem_addr=0x10 and mem_wdata=0xBEEF for one cycle; wr_done pulses 2 cycles after accept; memory word 0x10 reads 0xBEEF.
- Single read: preload 0x10=0xBEEF; req{we=0, addr=0x10, len=0} -> rsp_valid=1, rsp_data=0xBEEF, rsp_last=1 two cycles after accept; req_ready=1 the cycle after the handshake.
- Wrapping burst: preload 0xFE=0x1111, 0xFF=0x2222, 0x00=0x3333, 0x01=0x4444; read addr=0xFE, len=3 -> beats 0x1111, 0x2222, 0x3333, 0x4444 in order; rsp_last only on the 4th; mem_addr sequence FE, FF, 00, 01.
- Backpressure: same burst with rsp_ready=0 for 5 cycles on beat 2 -> rsp_data holds 0x2222 stable; mem_rd stays 0 throughout; no beat is lost or duplicated.
- Busy rejection: assert a write request while a burst is in RESP -> req_ready=0 and no mem_wr. The write is accepted only after rsp_last handshakes, then completes normally.
- Async reset mid-burst: drop rst between clock edges during READ -> mem_rd, rsp_valid, and rsp_last go 0 immediately; after release, req_ready=1 and no wr_done or rsp_valid appears without a new request.
